// File: rtl/multicycle_controller_pkg.sv
// ctrl_pkg: opcodes, state encoding and select encodings shared by the multicycle controller
package ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP      = 32'h00000013;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;
    typedef enum logic [1:0] {PC_4, PC_IMM, PC_ALU} pc_sel_t;
    typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4, WB_UIMM} wb_sel_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_BR, ALU_R, ALU_AUIPC} alu_op_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: fetch, data-side handshake and datapath control bundle of the controller
interface multicycle_controller_if #(parameter int XLEN = 32);
    logic [31:0]     inst_in;
    logic            if_ready;
    logic [XLEN-1:0] alu_result;
    logic            branch_taken;
    logic            mem_ready;
    logic            io_ready;
    logic [31:0]     ir;
    logic            if_req;
    logic            pc_we;
    logic [1:0]      pc_sel;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic            mem_req;
    logic            mem_we;
    logic            io_req;
    logic            io_we;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            reg_we;
    logic [1:0]      wb_sel;
    logic            illegal;
    logic [2:0]      state;
    modport master (
        input  inst_in, if_ready, alu_result, branch_taken, mem_ready, io_ready,
        output ir, if_req, pc_we, pc_sel, alu_src, alu_op, mem_req, mem_we, io_req, io_we,
               mem_size, mem_unsigned, reg_we, wb_sel, illegal, state
    );
    modport slave (
        output inst_in, if_ready, alu_result, branch_taken, mem_ready, io_ready,
        input  ir, if_req, pc_we, pc_sel, alu_src, alu_op, mem_req, mem_we, io_req, io_we,
               mem_size, mem_unsigned, reg_we, wb_sel, illegal, state
    );
endinterface

// File: rtl/multicycle_controller_decode.sv
// ctrl_decode: classifies the latched instruction and checks funct3 legality per class
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit HALF_EN = 1'b1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    output logic       is_r,
    output logic       is_i,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jal,
    output logic       is_jalr,
    output logic       is_lui,
    output logic       is_auipc,
    output logic [1:0] size,
    output logic       is_unsigned,
    output logic       legal
);
    logic ld_ok, st_ok, br_ok;
    assign is_r        = op == OP_R;
    assign is_i        = op == OP_I;
    assign is_load     = op == OP_LOAD;
    assign is_store    = op == OP_STORE;
    assign is_branch   = op == OP_BRANCH;
    assign is_jal      = op == OP_JAL;
    assign is_jalr     = op == OP_JALR;
    assign is_lui      = op == OP_LUI;
    assign is_auipc    = op == OP_AUIPC;
    assign size        = funct3[1:0];
    assign is_unsigned = funct3[2];
    assign ld_ok = funct3 inside {3'b000, 3'b010, 3'b100} || (HALF_EN && funct3 inside {3'b001, 3'b101});
    assign st_ok = funct3 inside {3'b000, 3'b010} || (HALF_EN && funct3 == 3'b001);
    assign br_ok = funct3[2:1] != 2'b01;
    assign legal = is_r || is_i || is_lui || is_auipc || is_jal || (is_jalr && funct3 == 3'b000)
                || (is_branch && br_ok) || (is_load && ld_ok) || (is_store && st_ok);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I fetch/decode/execute/memory/write-back sequencer driving datapath controls
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IO_LSB  = 10,
    parameter bit HALF_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    multicycle_controller_if.master bus
);
    state_t     state, nxt;
    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic [1:0] size;
    logic       is_unsigned, legal;
    logic       pc_we_q;
    logic [1:0] pc_sel_q;
    logic       io_addr, mem_io, misaligned, done, in_alu, unused_addr;

    ctrl_decode #(.HALF_EN(HALF_EN)) u_decode (
        .op(bus.ir[6:0]), .funct3(bus.ir[14:12]),
        .is_r(is_r), .is_i(is_i), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui), .is_auipc(is_auipc),
        .size(size), .is_unsigned(is_unsigned), .legal(legal)
    );

    assign io_addr     = &bus.alu_result[XLEN-1:IO_LSB];
    assign mem_io      = (state == S_MEM) ? bus.io_req : io_addr;
    assign misaligned  = (size == SZ_H && bus.alu_result[0]) || (size == SZ_W && bus.alu_result[1:0] != 2'b00);
    assign done        = (bus.mem_req && bus.mem_ready) || (bus.io_req && bus.io_ready);
    assign in_alu      = nxt == S_EXEC || nxt == S_MEM;
    assign unused_addr = ^bus.alu_result[IO_LSB-1:2];
    assign bus.state   = state;
    // a store retires on the cycle its ready arrives, so its PC update follows that ready
    assign bus.pc_we   = pc_we_q || (state == S_MEM && is_store && done);
    assign bus.pc_sel  = (state == S_EXEC && is_branch) ? {1'b0, bus.branch_taken} : pc_sel_q;

    // next-state sequencing
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:  nxt = (bus.if_req && bus.if_ready) ? S_DECODE : S_FETCH;
            S_DECODE: nxt = legal ? S_EXEC : S_TRAP;
            S_EXEC:   nxt = is_branch ? S_FETCH : (is_load || is_store) ? (misaligned ? S_TRAP : S_MEM) : S_WB;
            S_MEM:    nxt = !done ? S_MEM : is_load ? S_WB : S_FETCH;
            S_WB:     nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    // state, latched instruction and Moore outputs registered from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_FETCH;
            bus.ir           <= NOP;
            bus.illegal      <= 1'b0;
            bus.if_req       <= 1'b0;
            pc_we_q          <= 1'b0;
            pc_sel_q         <= PC_4;
            bus.alu_src      <= 1'b0;
            bus.alu_op       <= ALU_ADD;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.io_req       <= 1'b0;
            bus.io_we        <= 1'b0;
            bus.mem_size     <= SZ_B;
            bus.mem_unsigned <= 1'b0;
            bus.reg_we       <= 1'b0;
            bus.wb_sel       <= WB_ALU;
        end else begin
            state            <= nxt;
            if (nxt == S_DECODE) bus.ir <= bus.inst_in;
            bus.illegal      <= nxt == S_TRAP;
            bus.if_req       <= nxt == S_FETCH;
            pc_we_q          <= nxt == S_WB || (nxt == S_EXEC && is_branch);
            pc_sel_q         <= nxt != S_WB ? PC_4 : is_jal ? PC_IMM : is_jalr ? PC_ALU : PC_4;
            bus.alu_src      <= in_alu && (is_i || is_load || is_store || is_jalr || is_lui || is_auipc);
            bus.alu_op       <= !in_alu ? ALU_ADD : is_r ? ALU_R : is_branch ? ALU_BR : is_auipc ? ALU_AUIPC : ALU_ADD;
            bus.mem_req      <= nxt == S_MEM && !mem_io;
            bus.mem_we       <= nxt == S_MEM && !mem_io && is_store;
            bus.io_req       <= nxt == S_MEM && mem_io;
            bus.io_we        <= nxt == S_MEM && mem_io && is_store;
            bus.mem_size     <= nxt == S_MEM ? size : 2'd0;
            bus.mem_unsigned <= nxt == S_MEM && is_unsigned;
            bus.reg_we       <= nxt == S_WB;
            bus.wb_sel       <= nxt != S_WB ? WB_ALU : is_load ? WB_LOAD : (is_jal || is_jalr) ? WB_PC4 : is_lui ? WB_UIMM : WB_ALU;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized bench checking the controller against an instruction-level phase model
module tb_multicycle_controller;
    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd7;

    typedef struct {
        logic [2:0] st;
        logic       if_req, pc_we;
        logic [1:0] pc_sel;
        logic       alu_chk, src_chk, alu_src;
        logic [1:0] alu_op;
        logic       mem_req, mem_we, io_req, io_we;
        logic [1:0] mem_size;
        logic       mem_uns, reg_we;
        logic [1:0] wb_sel;
        logic       ill, rdy;
    } ph_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ph_t  exp_q[$];

    multicycle_controller_if #(.XLEN(32)) bus();
    multicycle_controller_if #(.XLEN(32)) bus_nh();

    multicycle_controller #(.XLEN(32), .IO_LSB(10), .HALF_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    multicycle_controller #(.XLEN(32), .IO_LSB(10), .HALF_EN(1'b0)) dut_nh (.clk(clk), .rst(rst), .bus(bus_nh.master));

    assign bus_nh.inst_in      = bus.inst_in;
    assign bus_nh.if_ready     = bus.if_ready;
    assign bus_nh.alu_result   = bus.alu_result;
    assign bus_nh.branch_taken = bus.branch_taken;
    assign bus_nh.mem_ready    = bus.mem_ready;
    assign bus_nh.io_ready     = bus.io_ready;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ph_t phase(input logic [2:0] st);
        ph_t p = '{default: '0};
        p.st  = st;
        p.ill = (st == ST_T);
        return p;
    endfunction

    // expected per-cycle behaviour of one instruction, derived from the instruction's class
    task automatic build(input logic [31:0] inst, input logic [31:0] addr, input logic taken,
                         input int fw, input int mw, input bit half_en);
        logic [6:0] op;
        logic [2:0] f3;
        bit r, i, ld, st, br, jal, jalr, lui, aui, legal, io, mis;
        ph_t p;
        op = inst[6:0];
        f3 = inst[14:12];
        r = op == 7'h33; i = op == 7'h13; ld = op == 7'h03; st = op == 7'h23; br = op == 7'h63;
        jal = op == 7'h6F; jalr = op == 7'h67; lui = op == 7'h37; aui = op == 7'h17;
        legal = r || i || jal || lui || aui || (jalr && f3 == 3'd0) || (br && f3 != 3'd2 && f3 != 3'd3)
             || (ld && (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd4 || (half_en && (f3 == 3'd1 || f3 == 3'd5))))
             || (st && (f3 == 3'd0 || f3 == 3'd2 || (half_en && f3 == 3'd1)));
        io  = &addr[31:10];
        mis = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        exp_q.delete();
        for (int k = 0; k <= fw; k++) begin
            p = phase(ST_F); p.if_req = 1'b1; p.rdy = (k == fw); exp_q.push_back(p);
        end
        exp_q.push_back(phase(ST_D));
        if (!legal) begin
            repeat (3) exp_q.push_back(phase(ST_T));
            return;
        end
        p = phase(ST_E);
        p.alu_chk = 1'b1;
        p.src_chk = !(jal || lui);
        p.alu_src = i || ld || st || jalr || aui;
        p.alu_op  = r ? 2'd2 : br ? 2'd1 : aui ? 2'd3 : 2'd0;
        if (br) begin
            p.pc_we = 1'b1; p.pc_sel = {1'b0, taken}; exp_q.push_back(p);
            return;
        end
        exp_q.push_back(p);
        if (ld || st) begin
            if (mis) begin
                repeat (3) exp_q.push_back(phase(ST_T));
                return;
            end
            for (int k = 0; k <= mw; k++) begin
                p = phase(ST_M);
                p.mem_req = !io; p.io_req = io; p.mem_we = !io && st; p.io_we = io && st;
                p.mem_size = f3[1:0]; p.mem_uns = f3[2]; p.rdy = (k == mw);
                p.pc_we = st && (k == mw);
                exp_q.push_back(p);
            end
            if (st) return;
        end
        p = phase(ST_W);
        p.reg_we = 1'b1; p.pc_we = 1'b1;
        p.wb_sel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
        p.pc_sel = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
        exp_q.push_back(p);
    endtask

    // drive one instruction through the DUT and compare every cycle with the phase list
    task automatic run(input string nm, input logic [31:0] inst, input logic [31:0] addr, input logic taken);
        ph_t p;
        bus.inst_in    = inst;
        bus.alu_result = addr;
        for (int k = 0; k < exp_q.size(); k++) begin
            p = exp_q[k];
            bus.if_ready     = (p.st == ST_F) ? p.rdy : 1'($urandom);
            bus.mem_ready    = p.mem_req ? p.rdy : 1'($urandom);
            bus.io_ready     = p.io_req ? p.rdy : 1'($urandom);
            bus.branch_taken = (p.st == ST_E) ? taken : 1'($urandom);
            #1;
            checks++;
            if (bus.state !== p.st) begin
                errors++;
                $display("FAIL %s state cyc %0d: got %0d want %0d", nm, k, bus.state, p.st);
            end
            checks++;
            if ({bus.if_req, bus.pc_we, bus.pc_sel, bus.mem_req, bus.mem_we, bus.io_req, bus.io_we, bus.reg_we, bus.illegal}
                !== {p.if_req, p.pc_we, p.pc_sel, p.mem_req, p.mem_we, p.io_req, p.io_we, p.reg_we, p.ill}) begin
                errors++;
                $display("FAIL %s strobes cyc %0d: got if_req=%b pc_we=%b pc_sel=%0d mreq=%b mwe=%b ioreq=%b iowe=%b reg_we=%b ill=%b want %b %b %0d %b %b %b %b %b %b",
                         nm, k, bus.if_req, bus.pc_we, bus.pc_sel, bus.mem_req, bus.mem_we, bus.io_req, bus.io_we, bus.reg_we, bus.illegal,
                         p.if_req, p.pc_we, p.pc_sel, p.mem_req, p.mem_we, p.io_req, p.io_we, p.reg_we, p.ill);
            end
            if (p.alu_chk) begin
                checks++;
                if (bus.alu_op !== p.alu_op || (p.src_chk && bus.alu_src !== p.alu_src)) begin
                    errors++;
                    $display("FAIL %s alu cyc %0d: got op=%0d src=%b want op=%0d src=%b", nm, k, bus.alu_op, bus.alu_src, p.alu_op, p.alu_src);
                end
            end
            if (p.st == ST_M) begin
                checks++;
                if (bus.mem_size !== p.mem_size || bus.mem_unsigned !== p.mem_uns) begin
                    errors++;
                    $display("FAIL %s size cyc %0d: got %0d/%b want %0d/%b", nm, k, bus.mem_size, bus.mem_unsigned, p.mem_size, p.mem_uns);
                end
            end
            if (p.reg_we) begin
                checks++;
                if (bus.wb_sel !== p.wb_sel) begin
                    errors++;
                    $display("FAIL %s wb_sel cyc %0d: got %0d want %0d", nm, k, bus.wb_sel, p.wb_sel);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.if_ready = 1'b0; bus.mem_ready = 1'b0; bus.io_ready = 1'b0;
        bus.branch_taken = 1'b0; bus.inst_in = 32'h0; bus.alu_result = 32'h0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.if_req, bus.pc_we, bus.pc_sel, bus.alu_src, bus.alu_op, bus.mem_req, bus.mem_we, bus.io_req, bus.io_we,
             bus.mem_size, bus.mem_unsigned, bus.reg_we, bus.wb_sel, bus.illegal, bus.state, bus_nh.illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got if_req=%b pc_we=%b state=%0d illegal=%b nh_illegal=%b want all 0",
                     bus.if_req, bus.pc_we, bus.state, bus.illegal, bus_nh.illegal);
        end
        checks++;
        if (bus.ir !== 32'h00000013) begin
            errors++;
            $display("FAIL reset_ir: got %h want 00000013", bus.ir);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_req !== 1'b1 || bus.state !== ST_F) begin
            errors++;
            $display("FAIL reset_release: got if_req=%b state=%0d want 1/0", bus.if_req, bus.state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.if_ready = 1'b1; bus.mem_ready = 1'b1; bus.io_ready = 1'b1;
            bus.branch_taken = 1'($urandom); bus.inst_in = $urandom; bus.alu_result = $urandom;
            @(negedge clk);
            #1;
            checks++;
            if ({bus.if_req, bus.pc_we, bus.mem_req, bus.io_req, bus.reg_we, bus.illegal, bus.state} !== '0 || bus.ir !== 32'h00000013) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got if_req=%b state=%0d ir=%h want 0/0/00000013", k, bus.if_req, bus.state, bus.ir);
            end
        end
        do_reset();
    endtask

    task automatic test_add();
        build(32'h003100B3, 32'h0, 1'b0, 0, 0, 1'b1);
        run("add", 32'h003100B3, 32'h0, 1'b0);
    endtask

    task automatic test_io_load();
        build(32'h0000A083, 32'hFFFFFC60, 1'b0, 0, 3, 1'b1);
        run("lw_io", 32'h0000A083, 32'hFFFFFC60, 1'b0);
    endtask

    task automatic test_store();
        build(32'h0020A223, 32'h00000104, 1'b0, 1, 0, 1'b1);
        run("sw_mem", 32'h0020A223, 32'h00000104, 1'b0);
    endtask

    task automatic test_branch();
        build(32'h00208463, 32'h0, 1'b1, 0, 0, 1'b1);
        run("beq_taken", 32'h00208463, 32'h0, 1'b1);
        build(32'h00208463, 32'h0, 1'b0, 2, 0, 1'b1);
        run("beq_not", 32'h00208463, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};
        logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic [31:0] r, inst, addr;
            logic tk;
            int fw, mw;
            op = ops[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            if (op == 7'h03) f3 = ld_f3[$urandom_range(0, 4)];
            if (op == 7'h23) f3 = st_f3[$urandom_range(0, 2)];
            if (op == 7'h63) f3 = br_f3[$urandom_range(0, 5)];
            if (op == 7'h67) f3 = 3'd0;
            r = $urandom;
            inst = {r[31:15], f3, r[11:7], op};
            addr = $urandom;
            if ($urandom_range(0, 2) == 0) addr[31:10] = '1;
            if (f3[1:0] == 2'd1) addr[0] = 1'b0;
            if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            tk = 1'($urandom);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            build(inst, addr, tk, fw, mw, 1'b1);
            run($sformatf("rnd%0d", n), inst, addr, tk);
        end
    endtask

    task automatic test_half_disabled();
        do_reset();
        build(32'h00009083, 32'h00000202, 1'b0, 0, 1, 1'b1);
        run("lh_half_en", 32'h00009083, 32'h00000202, 1'b0);
        checks++;
        if (bus_nh.state !== ST_T || bus_nh.illegal !== 1'b1) begin
            errors++;
            $display("FAIL lh_no_half: got state=%0d illegal=%b want 7/1", bus_nh.state, bus_nh.illegal);
        end
    endtask

    task automatic test_traps();
        build(32'h0000A083, 32'h00000102, 1'b0, 0, 0, 1'b1);
        run("lw_misaligned", 32'h0000A083, 32'h00000102, 1'b0);
        do_reset();
        build(32'h0000007F, 32'h0, 1'b0, 1, 0, 1'b1);
        run("bad_opcode", 32'h0000007F, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.illegal !== 1'b0 || bus.state !== ST_F) begin
            errors++;
            $display("FAIL trap_clear: got illegal=%b state=%0d want 0/0", bus.illegal, bus.state);
        end
        do_reset();
    endtask

    task automatic test_rst_mid();
        int n = 0;
        bus.inst_in = 32'h0020A223; bus.alu_result = 32'h00000100;
        bus.if_ready = 1'b1; bus.mem_ready = 1'b0; bus.io_ready = 1'b0;
        while (bus.state !== ST_M && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.state !== ST_M || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: got state=%0d mem_req=%b mem_we=%b want 3/1/1", bus.state, bus.mem_req, bus.mem_we);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.io_req, bus.pc_we, bus.reg_we, bus.illegal} !== '0 || bus.state !== ST_F || bus.ir !== 32'h00000013) begin
            errors++;
            $display("FAIL rst_mid: got mem_req=%b mem_we=%b pc_we=%b state=%0d ir=%h want 0/0/0/0/00000013",
                     bus.mem_req, bus.mem_we, bus.pc_we, bus.state, bus.ir);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_add();
        test_io_load();
        test_store();
        test_branch();
        test_random();
        test_half_disabled();
        test_traps();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
